button_peripheral: RTL and testbench
====================================

BUTTON_PERIPHERAL -- requirements
Module: button_peripheral

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 50000; consecutive stable clocks needed to accept a new button level, legal range 2..65535.
REQ-002 Parameter: NUM_BUTTONS, default 8; button input count, legal range 1..32.
REQ-003 Port: clk  input  1  single system clock, all logic on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: rd_en_i  input  1  processor read strobe.
REQ-006 Port: wr_en_i  input  1  processor write strobe.
REQ-007 Port: addr_i  input  32  byte address; only addr_i[3:0] decoded.
REQ-008 Port: data_i  input  32  write data.
REQ-009 Port: data_o  output  32  read data, combinational.
REQ-010 Port: buttons_i  input  NUM_BUTTONS  asynchronous raw button levels, active-high.
REQ-011 Port: irq_o  output  1  level interrupt request.

Function
REQ-012 Each buttons_i bit SHALL pass a 2-flop synchronizer before any other use.
REQ-013 Per bit: while synchronized level differs from debounced state, a counter SHALL increment once per clock; on the DEBOUNCE_CYCLES-th consecutive mismatching clock, debounced state SHALL take the synchronized level and the counter SHALL clear.
REQ-014 Any clock with synchronized level equal to debounced state SHALL clear that bit's counter (glitch rejection).
REQ-015 Pin-to-debounced-state latency SHALL be exactly 2 + DEBOUNCE_CYCLES clocks for a clean level change.
REQ-016 A 0->1 transition of a debounced bit SHALL set the corresponding EDGE bit in the same clock the state updates; 1->0 transitions SHALL NOT set EDGE.
REQ-017 Register map (offset addr_i[3:0]): 0x0 STATE (RO, debounced state); 0x4 EDGE (R/W1C, latched rising edges); 0x8 IRQ_EN (RW, per-bit mask); 0xC RAW (RO, synchronized levels).
REQ-018 Read: data_o SHALL equal the addressed register zero-extended to 32 bits when rd_en_i=1 and offset is mapped; otherwise 32'h0; reads SHALL have no side effects.
REQ-019 Write to 0x4: each EDGE bit with data_i bit=1 SHALL clear at the next clock edge; bits with 0 unchanged.
REQ-020 Write to 0x8: IRQ_EN SHALL load data_i[NUM_BUTTONS-1:0] at the next clock edge.
REQ-021 Writes to 0x0, 0xC or unmapped offsets SHALL be ignored.
REQ-022 Simultaneous W1C and new rising edge on the same bit SHALL leave the bit set (set wins).
REQ-023 irq_o SHALL equal OR of (EDGE AND IRQ_EN), combinational from registers, no added latency.
REQ-024 rd_en_i and wr_en_i asserted together SHALL perform both operations; read returns pre-write value.

Reset
REQ-025 rst_n low SHALL asynchronously clear synchronizer flops, counters, STATE, EDGE, IRQ_EN; irq_o=0, data_o=0 while strobes low.
REQ-026 A button held high through reset deassertion SHALL produce a rising edge 2 + DEBOUNCE_CYCLES clocks after release of reset.
REQ-027 Reset mid-debounce SHALL discard partial count; no edge from the aborted transition.

Structure
REQ-028 Register offsets (0x0/0x4/0x8/0xC) SHALL be constants in shared package button_peripheral_pkg.
REQ-029 Synchronizer plus counter per bit SHALL be sub-module button_debouncer, instantiated NUM_BUTTONS times via generate.
REQ-030 Counter width SHALL be 16 bits.

Verification (DEBOUNCE_CYCLES=4, NUM_BUTTONS=8)
REQ-031 buttons_i=8'h01 held -> STATE reads 8'h01 exactly 6 clocks later, EDGE reads 8'h01.
REQ-032 buttons_i bit1 high for 3 clocks then low -> STATE and EDGE stay 8'h00.
REQ-033 EDGE=8'h05, write 0x4 data 32'h4 -> EDGE reads 8'h01 next clock; writing 0 to 0x4 -> unchanged.
REQ-034 IRQ_EN=8'h02, rising edge on bit0 -> irq_o=0; rising edge on bit1 -> irq_o=1; W1C 32'h2 -> irq_o=0 next clock.
REQ-035 W1C bit3 in same clock as bit3 debounced rise -> EDGE bit3 remains 1.
REQ-036 rst_n pulsed low at count 2 of bit2 transition -> all reads 0, no EDGE; read of offset 0x10 or without rd_en_i -> 32'h0.

Source files
------------

// File: rtl/button_peripheral_pkg.sv
// Shared constants for the button peripheral: register offsets and counter width.
package button_peripheral_pkg;

  typedef enum logic [3:0] {
    REG_STATE  = 4'h0,
    REG_EDGE   = 4'h4,
    REG_IRQ_EN = 4'h8,
    REG_RAW    = 4'hC
  } reg_offset_e;

  localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/button_debouncer.sv
// One button: 2-flop synchronizer followed by a consecutive-mismatch debounce counter.
module button_debouncer
  import button_peripheral_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic sync_level,
  output logic state,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta;
  logic [CNT_W-1:0] cnt;
  logic             mismatch;
  logic             accept;

  assign mismatch = (sync_level != state);
  // The DEBOUNCE_CYCLES-th mismatching clock is the one that sees cnt at its last value.
  assign accept   = mismatch && (cnt == CNT_LAST);
  assign rise     = accept && sync_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta       <= 1'b0;
      sync_level <= 1'b0;
      state      <= 1'b0;
      cnt        <= '0;
    end else begin
      meta       <= button;
      sync_level <= meta;
      if (accept) begin
        state <= sync_level;
        cnt   <= '0;
      end else if (mismatch) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/button_peripheral.sv
// Debounced button bank with rising-edge latch, per-bit interrupt mask and a small register file.
module button_peripheral
  import button_peripheral_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned NUM_BUTTONS     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rd_en_i,
  input  logic                   wr_en_i,
  input  logic [31:0]            addr_i,
  input  logic [31:0]            data_i,
  output logic [31:0]            data_o,
  input  logic [NUM_BUTTONS-1:0] buttons_i,
  output logic                   irq_o
);

  logic [NUM_BUTTONS-1:0] raw_level;
  logic [NUM_BUTTONS-1:0] state;
  logic [NUM_BUTTONS-1:0] rise;
  logic [NUM_BUTTONS-1:0] edge_q;
  logic [NUM_BUTTONS-1:0] irq_en_q;
  logic [NUM_BUTTONS-1:0] edge_clr;
  logic                   irq_en_wr;
  logic                   unused;

  assign unused = ^{addr_i[31:4], data_i};

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk        (clk),
      .rst_n      (rst_n),
      .button     (buttons_i[i]),
      .sync_level (raw_level[i]),
      .state      (state[i]),
      .rise       (rise[i])
    );
  end

  assign edge_clr  = (wr_en_i && (addr_i[3:0] == REG_EDGE)) ? data_i[NUM_BUTTONS-1:0] : '0;
  assign irq_en_wr = wr_en_i && (addr_i[3:0] == REG_IRQ_EN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_q   <= '0;
      irq_en_q <= '0;
    end else begin
      // Set is ORed in after the clear so a simultaneous new edge survives W1C.
      edge_q <= (edge_q & ~edge_clr) | rise;
      if (irq_en_wr) begin
        irq_en_q <= data_i[NUM_BUTTONS-1:0];
      end
    end
  end

  always_comb begin
    data_o = '0;
    if (rd_en_i) begin
      case (addr_i[3:0])
        REG_STATE:  data_o = 32'(state);
        REG_EDGE:   data_o = 32'(edge_q);
        REG_IRQ_EN: data_o = 32'(irq_en_q);
        REG_RAW:    data_o = 32'(raw_level);
        default:    data_o = '0;
      endcase
    end
  end

  assign irq_o = |(edge_q & irq_en_q);

endmodule

// File: tb/tb_button_peripheral.sv
// Scoreboard bench for button_peripheral with DEBOUNCE_CYCLES=4, NUM_BUTTONS=8.
module tb_button_peripheral;
  import button_peripheral_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        rd_en_i;
  logic        wr_en_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic [7:0]  buttons_i;
  logic        irq_o;

  int unsigned n_tests;
  int unsigned n_fail;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  button_peripheral #(
    .DEBOUNCE_CYCLES(4),
    .NUM_BUTTONS    (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en_i   (rd_en_i),
    .wr_en_i   (wr_en_i),
    .addr_i    (addr_i),
    .data_i    (data_i),
    .data_o    (data_o),
    .buttons_i (buttons_i),
    .irq_o     (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic observe(input logic [31:0] got);
    string       t;
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_underflow: got %h expected <none>", got);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check(t, got, e);
    end
  endtask

  task automatic tick(input int unsigned n = 1);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd_obs(input logic [31:0] addr);
    logic [31:0] d;
    addr_i  = addr;
    rd_en_i = 1'b1;
    #1;
    d       = data_o;
    rd_en_i = 1'b0;
    addr_i  = '0;
    observe(d);
  endtask

  task automatic irq_obs();
    observe({31'b0, irq_o});
  endtask

  // Write strobe is sampled by the next rising edge; returns #1 after it.
  task automatic wr(input logic [31:0] addr, input logic [31:0] d);
    addr_i  = addr;
    data_i  = d;
    wr_en_i = 1'b1;
    tick();
    wr_en_i = 1'b0;
    addr_i  = '0;
    data_i  = '0;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    rd_en_i   = 1'b0;
    wr_en_i   = 1'b0;
    addr_i    = '0;
    data_i    = '0;
    buttons_i = '0;

    // Reset state
    tick(3);
    expect_val("rst_irq", 0);
    expect_val("rst_data_idle", 0);
    expect_val("rst_state", 0);
    expect_val("rst_irq_en", 0);
    irq_obs();
    observe(data_o);
    rd_obs(REG_STATE);
    rd_obs(REG_IRQ_EN);
    rst_n = 1'b1;

    // Clean press on bit0: RAW after 2 clocks, STATE exactly after 6
    buttons_i = 8'h01;
    expect_val("raw_k1", 32'h00);
    expect_val("raw_k2", 32'h01);
    expect_val("state_k5", 32'h00);
    expect_val("state_k6", 32'h01);
    expect_val("edge_k6", 32'h01);
    tick(); rd_obs(REG_RAW);
    tick(); rd_obs(REG_RAW);
    tick(3); rd_obs(REG_STATE);
    tick(); rd_obs(REG_STATE); rd_obs(REG_EDGE);

    // Release: falling transition must not set EDGE
    buttons_i = 8'h00;
    expect_val("state_released", 32'h00);
    expect_val("edge_after_fall", 32'h01);
    tick(6); rd_obs(REG_STATE); rd_obs(REG_EDGE);
    wr(REG_EDGE, 32'hFF);
    expect_val("edge_cleared", 32'h00);
    rd_obs(REG_EDGE);

    // 3-clock glitch on bit1 is rejected
    buttons_i = 8'h02;
    tick(3);
    buttons_i = 8'h00;
    expect_val("glitch_state", 32'h00);
    expect_val("glitch_edge", 32'h00);
    tick(10); rd_obs(REG_STATE); rd_obs(REG_EDGE);

    // EDGE=05, W1C bit2, W1C with 0, writes to RO/unmapped ignored
    buttons_i = 8'h05;
    tick(6);
    buttons_i = 8'h00;
    tick(6);
    expect_val("edge_05", 32'h05);
    rd_obs(REG_EDGE);
    wr(REG_EDGE, 32'h4);
    expect_val("w1c_bit2", 32'h01);
    rd_obs(REG_EDGE);
    wr(REG_EDGE, 32'h0);
    expect_val("w1c_zero", 32'h01);
    rd_obs(REG_EDGE);
    wr(REG_STATE, 32'hFF);
    wr(REG_RAW, 32'hFF);
    wr(32'h2, 32'hFF);
    expect_val("ro_state", 32'h00);
    expect_val("ro_raw", 32'h00);
    expect_val("ro_edge", 32'h01);
    rd_obs(REG_STATE); rd_obs(REG_RAW); rd_obs(REG_EDGE);
    wr(REG_EDGE, 32'hFF);

    // Interrupt mask
    wr(REG_IRQ_EN, 32'hFFFF_FF02);
    expect_val("irq_en_rd", 32'h02);
    rd_obs(REG_IRQ_EN);
    buttons_i = 8'h01;
    expect_val("irq_masked", 0);
    expect_val("edge_bit0", 32'h01);
    tick(6); irq_obs(); rd_obs(REG_EDGE);
    buttons_i = 8'h03;
    expect_val("irq_k5", 0);
    expect_val("irq_k6", 1);
    tick(5); irq_obs();
    tick(); irq_obs();
    wr(REG_EDGE, 32'h2);
    expect_val("irq_after_w1c", 0);
    irq_obs();
    buttons_i = 8'h00;
    tick(8);
    wr(REG_EDGE, 32'hFF);

    // W1C in the same clock as bit3 rise: set wins
    buttons_i = 8'h08;
    tick(5);
    expect_val("edge_before_rise", 32'h00);
    rd_obs(REG_EDGE);
    wr(REG_EDGE, 32'h8);
    expect_val("set_wins", 32'h08);
    rd_obs(REG_EDGE);

    // Simultaneous read and W1C returns pre-write value
    addr_i  = REG_EDGE;
    data_i  = 32'h8;
    rd_en_i = 1'b1;
    wr_en_i = 1'b1;
    #1;
    expect_val("rdwr_prewrite", 32'h08);
    observe(data_o);
    tick();
    rd_en_i = 1'b0;
    wr_en_i = 1'b0;
    expect_val("rdwr_postwrite", 32'h00);
    rd_obs(REG_EDGE);
    buttons_i = 8'h00;
    tick(8);

    // Reset mid-debounce of bit2
    buttons_i = 8'h04;
    tick(4);
    rst_n     = 1'b0;
    buttons_i = 8'h00;
    #1;
    expect_val("mid_rst_state", 0);
    expect_val("mid_rst_edge", 0);
    expect_val("mid_rst_irq_en", 0);
    expect_val("mid_rst_irq", 0);
    expect_val("rd_0x10", 0);
    rd_obs(REG_STATE); rd_obs(REG_EDGE); rd_obs(REG_IRQ_EN); irq_obs();
    rd_obs(32'h10);
    rst_n = 1'b1;
    expect_val("aborted_edge", 0);
    expect_val("aborted_state", 0);
    tick(10); rd_obs(REG_EDGE); rd_obs(REG_STATE);

    // Button held through reset release
    buttons_i = 8'h10;
    tick(2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    expect_val("held_k5", 32'h00);
    expect_val("held_k6_edge", 32'h10);
    expect_val("held_k6_state", 32'h10);
    tick(5); rd_obs(REG_EDGE);
    tick(); rd_obs(REG_EDGE); rd_obs(REG_STATE);

    // Decode: unmapped offset, no strobe, aliased upper address bits
    expect_val("rd_unmapped", 0);
    expect_val("rd_no_strobe", 0);
    expect_val("rd_alias_0x14", 32'h10);
    rd_obs(32'h2);
    addr_i = REG_STATE;
    #1;
    observe(data_o);
    rd_obs(32'h14);

    check("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
